// File: rtl/burst_pkg.sv
// Shared definitions for the burst read responder: FSM encoding, default
// latency and the single supported beat size (32-bit words).
// No logic; imported by burst_read_responder and its testbench.
package burst_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Idle cycles between request capture and the first beat.
   localparam int DEF_LATENCY = 2;

   // log2(bytes per beat); every request is served with this size.
   localparam int BEAT_SIZE = 2;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;   // holds LATENCY-1 for LATENCY in 1..15

endpackage

// File: rtl/mem_array.sv
// Backing store: 2^ADDR_W x 32-bit words, one sync read port, one write port.
// Latency: read data valid the cycle after i_re; writes land at the clock edge.
// Backpressure: none; a read and a write to the same word in one cycle return old data.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_re/i_raddr read request; o_rdata read data.
module mem_array
   import burst_pkg::*;
#(
   parameter int ADDR_W = 10
)(
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_rdata;

   // Contents are deliberately not reset so a preload survives rstn.
   // The read samples the array before this edge's write: read-first.
   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      if (i_re)
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/burst_read_responder.sv
// Burst read responder: captures a cache read request and streams rlen+1 words from mem_array.
// Latency: first beat LATENCY+1 cycles after the capture edge, then one beat per cycle.
// Backpressure: none; rvalid is only sampled in IDLE and the burst always runs to completion.
// Ports: clk/rstn (sync, active-low); rvalid/raddr/rlen/rsize request;
//        rready/rdata/rlast beat output; we/waddr/wdata backdoor preload.
module burst_read_responder
   import burst_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int LATENCY        = DEF_LATENCY
)(
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      rvalid,
   input  logic [31:0]               raddr,
   input  logic [7:0]                rlen,
   input  logic [2:0]                rsize,
   output logic                      rready,
   output logic [DATA_W-1:0]         rdata,
   output logic                      rlast,
   input  logic                      we,
   input  logic [MEM_ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_W-1:0]         wdata
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CNT_W-1:0]          r_cnt;
   logic [MEM_ADDR_WIDTH-1:0] r_addr;     // word to read next
   logic [7:0]                r_left;     // beats still to come after the one being read
   logic                      r_rready;
   logic                      r_rlast;
   logic                      w_cap;
   logic                      w_rd_en;
   logic [DATA_W-1:0]         w_mem_rdata;

   // rsize is accepted but every request is served as 32-bit words, so the
   // word address always comes from the fixed BEAT_SIZE slice of raddr.
   always_comb begin
      w_state_nxt = r_state;
      w_cap       = 1'b0;
      w_rd_en     = 1'b0;
      case (r_state)
         IDLE: begin
            if (rvalid) begin
               w_cap       = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_rd_en     = 1'b1;
               w_state_nxt = BURST;
            end
         end
         BURST: begin
            // The beat on the bus now is the last one when nothing is left.
            if (r_left == 8'd0)
               w_state_nxt = DONE;
            else
               w_rd_en = 1'b1;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_left   <= '0;
         r_rready <= 1'b0;
         r_rlast  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_cap) begin
            r_addr <= raddr[MEM_ADDR_WIDTH+BEAT_SIZE-1:BEAT_SIZE];
            r_left <= rlen;
            r_cnt  <= CNT_LOAD;
         end else if (r_state == WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end

         if (w_rd_en) begin
            // Natural wrap at 2^MEM_ADDR_WIDTH words.
            r_addr <= r_addr + MEM_ADDR_WIDTH'(1);
            // The first read (from WAIT) does not consume r_left: it counts
            // the beats that follow the first one.
            if (r_state == BURST)
               r_left <= r_left - 8'd1;
         end

         r_rready <= w_rd_en;
         r_rlast  <= w_rd_en && ((r_state == WAIT) ? (r_left == 8'd0) : (r_left == 8'd1));
      end
   end

   mem_array #(
      .ADDR_W (MEM_ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_re    (w_rd_en),
      .i_raddr (r_addr),
      .o_rdata (w_mem_rdata)
   );

   assign rready = r_rready;
   assign rlast  = r_rlast;
   assign rdata  = r_rready ? w_mem_rdata : '0;

endmodule

// File: doc/burst_read_responder.md
BURST_READ_RESPONDER -- requirements
Module: burst_read_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 10, word-address bits of the backing store (2^10 words).
REQ-002 SHALL have parameter LATENCY, default 2, range 1..15, idle cycles between request capture and the first data beat.
REQ-003 SHALL have the port clk, input, 1 bit, the clock.
REQ-004 SHALL have the port rstn, input, 1 bit, the reset; synchronous, active-low.
REQ-005 SHALL have the port rvalid, input, 1 bit, read request valid from the cache; held high until the last beat is delivered.
REQ-006 SHALL have the port raddr, input, 32 bits, the burst start byte address.
REQ-007 SHALL have the port rlen, input, 8 bits, the beat count minus one.
REQ-008 SHALL have the port rsize, input, 3 bits, log2 of the bytes per beat.
REQ-009 SHALL have the port rready, output, 1 bit, high in every cycle a valid data beat is on rdata.
REQ-010 SHALL have the port rdata, output, 32 bits, the beat data.
REQ-011 SHALL have the port rlast, output, 1 bit, high with the final beat of a burst only.
REQ-012 SHALL have the port we, input, 1 bit, backdoor preload write enable.
REQ-013 SHALL have the port waddr, input, MEM_ADDR_WIDTH bits, backdoor word address.
REQ-014 SHALL have the port wdata, input, 32 bits, backdoor write data.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT, BURST and DONE.
REQ-016 IDLE, rvalid=1 at edge N: SHALL latch word address raddr[MEM_ADDR_WIDTH+1:2] and rlen, load the latency counter with LATENCY-1, and go to WAIT.
REQ-017 WAIT SHALL decrement the counter each cycle; at 0 it SHALL issue the memory read of the current word and go to BURST next cycle.
REQ-018 The first rready=1 SHALL occur in cycle N+LATENCY+1, counting cycle N+1 as the first WAIT cycle.
REQ-019 BURST SHALL deliver one beat per cycle, back-to-back, with no bubbles, and no backpressure input.
REQ-020 Total beats SHALL equal rlen+1; rlen=0 gives a single beat with rready=rlast=1.
REQ-021 The beat word address SHALL increment by 1 per beat and wrap modulo 2^MEM_ADDR_WIDTH, e.g. last word followed by word 0.
REQ-022 raddr[1:0] SHALL be ignored; beats are always 32-bit words.
REQ-023 rsize values other than 2 SHALL be served as rsize=2.
REQ-024 rdata SHALL be 0 whenever rready=0.
REQ-025 After the rlast beat the FSM SHALL go to DONE for exactly one cycle and ignore rvalid there, then return to IDLE.
REQ-026 rvalid falling during WAIT or BURST SHALL NOT abort the burst; all beats are still produced.
REQ-027 Any backdoor write SHALL take effect at the clock edge regardless of FSM state.
REQ-028 A beat read in the same cycle as a write to the same word SHALL return the old data (read-first).
REQ-029 raddr, rlen and rsize SHALL be sampled only at capture; later changes SHALL have no effect on the burst in flight.

Reset
REQ-030 rstn=0 at an edge SHALL force state=IDLE, rready=0, rlast=0, rdata=0, and clear the counter and burst registers.
REQ-031 Reset mid-burst SHALL abort the burst with no further beats; a request after reset release SHALL be served from its first beat.
REQ-032 Reset SHALL NOT clear memory contents.

Structure
REQ-033 State encoding, default LATENCY and the supported beat size constant SHALL reside in the shared package burst_pkg.
REQ-034 The backing store SHALL be one sub-module, mem_array: 32-bit words, one synchronous 1-cycle read port, one write port.
REQ-035 The FSM, counters and output registers SHALL remain in burst_read_responder.

Verification
REQ-036 Preload words 0x40..0x43 with 0xA0..0xA3; request raddr=0x100, rlen=3, LATENCY=2 -> rready cycles N+3..N+6 with data A0,A1,A2,A3 and rlast only at N+6.
REQ-037 rlen=0, raddr=0x8 -> exactly one beat, rready=rlast=1, data = word 2.
REQ-038 MEM_ADDR_WIDTH=4, raddr=0x38, rlen=3 -> words 14,15,0,1 returned in order.
REQ-039 Hold rvalid high through DONE -> no new capture in the DONE cycle; the next burst's first beat occurs LATENCY+1 cycles after IDLE re-entry.
REQ-040 Assert rstn=0 on the second beat of a rlen=7 burst -> rready=0 next cycle; a fresh request returns all 8 beats from its start address.
REQ-041 Backdoor write 0xDEAD to word 5 in the cycle word 5 is read -> beat shows old value; a repeat burst shows 0xDEAD.
